// File: rtl/byte_ram_2p.sv
// byte_ram_2p: byte-addressed little-endian RAM with a 1/2/4/8-byte load/store port and a wide fetch port.
// Optional feature macro RAM_INIT_CLEAR_EN: zero the array word by word after reset before serving requests.
module byte_ram_2p #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned DATA_BYTES  = 8,
  parameter int unsigned FETCH_BYTES = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     d_req_i,
  input  logic                     d_we_i,
  input  logic [1:0]               d_size_i,
  input  logic [ADDR_W-1:0]        d_addr_i,
  input  logic [DATA_BYTES*8-1:0]  d_wdata_i,
  output logic                     d_ready_o,
  output logic                     d_rvalid_o,
  output logic [DATA_BYTES*8-1:0]  d_rdata_o,
  output logic                     d_err_o,
  input  logic                     f_req_i,
  input  logic [ADDR_W-1:0]        f_addr_i,
  output logic                     f_ready_o,
  output logic                     f_rvalid_o,
  output logic [FETCH_BYTES*8-1:0] f_rdata_o,
  output logic                     f_err_o,
  output logic                     init_done_o
);

  localparam int unsigned ExtW   = ADDR_W + 1;
  localparam int unsigned IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DataW  = DATA_BYTES * 8;
  localparam int unsigned FetchW = FETCH_BYTES * 8;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e state_q, state_d;
  logic   run;

  logic [7:0] mem [DEPTH];

  logic              d_rvalid_q, d_rvalid_d;
  logic              d_err_q, d_err_d;
  logic [DataW-1:0]  d_rdata_q, d_rdata_d;
  logic              f_rvalid_q, f_rvalid_d;
  logic              f_err_q, f_err_d;
  logic [FetchW-1:0] f_rdata_q, f_rdata_d;

  logic [ExtW-1:0]   d_size_ext, d_end, f_end;
  logic              d_err, f_err;
  logic              d_acc, f_acc, d_store;
  logic [ADDR_W-1:0] d_idx, f_idx;
  logic [DataW-1:0]  d_load_data;
  logic [FetchW-1:0] f_load_data;

  assign run = (state_q == StRun);

  // Range checks use one extra bit so an address near the top cannot wrap past DEPTH.
  assign d_size_ext = ExtW'(1) << d_size_i;
  assign d_end      = {1'b0, d_addr_i} + d_size_ext;
  assign f_end      = {1'b0, f_addr_i} + ExtW'(FETCH_BYTES);
  assign d_err      = (d_size_ext > ExtW'(DATA_BYTES)) || (d_end > ExtW'(DEPTH));
  assign f_err      = (f_end > ExtW'(DEPTH));

  assign d_acc   = d_req_i & run;
  assign f_acc   = f_req_i & run;
  assign d_store = d_acc & d_we_i & ~d_err;

`ifdef RAM_INIT_CLEAR_EN
  localparam int unsigned Words = DEPTH / DATA_BYTES;
  localparam int unsigned CntW  = (Words > 1) ? $clog2(Words) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] clr_base;

  assign clr_base = IdxW'(cnt_q) * IdxW'(DATA_BYTES);
`endif

  always_comb begin
    state_d = state_q;
`ifdef RAM_INIT_CLEAR_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StInit: begin
`ifdef RAM_INIT_CLEAR_EN
        if (cnt_q == CntW'(Words - 1)) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`else
        state_d = StRun;
`endif
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    d_load_data = '0;
    d_idx       = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      d_idx = d_addr_i + ADDR_W'(i);
      if (ExtW'(i) < d_size_ext && d_idx < ADDR_W'(DEPTH)) begin
        d_load_data[8*i +: 8] = mem[d_idx[IdxW-1:0]];
      end
    end
  end

  always_comb begin
    f_load_data = '0;
    f_idx       = '0;
    for (int unsigned i = 0; i < FETCH_BYTES; i++) begin
      f_idx = f_addr_i + ADDR_W'(i);
      if (f_idx < ADDR_W'(DEPTH)) begin
        f_load_data[8*i +: 8] = mem[f_idx[IdxW-1:0]];
      end
    end
  end

  always_comb begin
    d_rvalid_d = d_acc;
    d_err_d    = d_acc & d_err;
    d_rdata_d  = (d_acc && !d_we_i && !d_err) ? d_load_data : '0;
    f_rvalid_d = f_acc;
    f_err_d    = f_acc & f_err;
    f_rdata_d  = (f_acc && !f_err) ? f_load_data : '0;
  end

  // Storage has no reset; the fetch path samples old contents on a same-edge store.
  always_ff @(posedge clk_i) begin
`ifdef RAM_INIT_CLEAR_EN
    if (!run) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        mem[clr_base + IdxW'(i)] <= 8'h00;
      end
    end else
`endif
    if (d_store) begin
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
        if (ExtW'(i) < d_size_ext) begin
          mem[d_addr_i[IdxW-1:0] + IdxW'(i)] <= d_wdata_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      d_rvalid_q <= 1'b0;
      d_err_q    <= 1'b0;
      d_rdata_q  <= '0;
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
      f_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      d_rvalid_q <= d_rvalid_d;
      d_err_q    <= d_err_d;
      d_rdata_q  <= d_rdata_d;
      f_rvalid_q <= f_rvalid_d;
      f_err_q    <= f_err_d;
      f_rdata_q  <= f_rdata_d;
    end
  end

`ifdef RAM_INIT_CLEAR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign d_ready_o   = run;
  assign f_ready_o   = run;
  assign init_done_o = run;
  assign d_rvalid_o  = d_rvalid_q;
  assign d_err_o     = d_err_q;
  assign d_rdata_o   = d_rdata_q;
  assign f_rvalid_o  = f_rvalid_q;
  assign f_err_o     = f_err_q;
  assign f_rdata_o   = f_rdata_q;

endmodule

// File: tb/tb_byte_ram_2p.sv
// Bench for byte_ram_2p: directed vector table, reset/init sequences and random traffic vs a byte-array model.
module tb_byte_ram_2p;

  localparam int unsigned Depth  = 1024;
  localparam int unsigned FetchB = 10;
  localparam int NVec = 18;
`ifdef RAM_INIT_CLEAR_EN
  localparam int ExpInit = 128;
`else
  localparam int ExpInit = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [1:0]  d_size = '0;
  logic [63:0] d_addr = '0, d_wdata = '0;
  logic        d_ready, d_rvalid, d_err;
  logic [63:0] d_rdata;
  logic        f_req = 1'b0;
  logic [63:0] f_addr = '0;
  logic        f_ready, f_rvalid, f_err;
  logic [79:0] f_rdata;
  logic        init_done;

  byte_ram_2p dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .d_req_i    (d_req),
    .d_we_i     (d_we),
    .d_size_i   (d_size),
    .d_addr_i   (d_addr),
    .d_wdata_i  (d_wdata),
    .d_ready_o  (d_ready),
    .d_rvalid_o (d_rvalid),
    .d_rdata_o  (d_rdata),
    .d_err_o    (d_err),
    .f_req_i    (f_req),
    .f_addr_i   (f_addr),
    .f_ready_o  (f_ready),
    .f_rvalid_o (f_rvalid),
    .f_rdata_o  (f_rdata),
    .f_err_o    (f_err),
    .init_done_o(init_done)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem_m [Depth];

  logic        e_dv, e_de, e_fv, e_fe;
  logic [63:0] e_dd;
  logic [79:0] e_fd;

  typedef struct {
    logic        dreq;
    logic        we;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        freq;
    logic [63:0] faddr;
    logic [63:0] edd;
    logic        ede;
    logic [79:0] efd;
    logic        efe;
  } vec_t;

  vec_t tab [NVec];

  function automatic vec_t mk(input logic dreq, we, input logic [1:0] size,
                              input logic [63:0] addr, wdata, input logic freq,
                              input logic [63:0] faddr, edd, input logic ede,
                              input logic [79:0] efd, input logic efe);
    vec_t v;
    v.dreq = dreq; v.we = we; v.size = size; v.addr = addr; v.wdata = wdata;
    v.freq = freq; v.faddr = faddr; v.edd = edd; v.ede = ede; v.efd = efd; v.efe = efe;
    return v;
  endfunction

  function automatic logic m_derr(input logic [1:0] size, input logic [63:0] addr);
    logic [64:0] last;
    last = {1'b0, addr} + (65'd1 << size);
    return (last > 65'(Depth)) || ((1 << size) > 8);
  endfunction

  function automatic logic m_ferr(input logic [63:0] addr);
    return ({1'b0, addr} + 65'(FetchB)) > 65'(Depth);
  endfunction

  function automatic logic [63:0] m_load(input logic [1:0] size, input logic [63:0] addr);
    logic [63:0] r;
    r = '0;
    if (!m_derr(size, addr))
      for (int k = 0; k < (1 << size); k++) r[8*k +: 8] = mem_m[int'(addr) + k];
    return r;
  endfunction

  function automatic logic [79:0] m_fetch(input logic [63:0] addr);
    logic [79:0] r;
    r = '0;
    if (!m_ferr(addr))
      for (int k = 0; k < FetchB; k++) r[8*k +: 8] = mem_m[int'(addr) + k];
    return r;
  endfunction

  task automatic m_store(input logic [1:0] size, input logic [63:0] addr, input logic [63:0] wd);
    if (!m_derr(size, addr))
      for (int k = 0; k < (1 << size); k++) mem_m[int'(addr) + k] = wd[8*k +: 8];
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request pair, takes expectations from the model (fetch/load before store), advances a cycle.
  task automatic do_cycle(input logic dreq, we, input logic [1:0] size, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic freq, input logic [63:0] faddr);
    d_req = dreq; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata;
    f_req = freq; f_addr = faddr;
    e_dv = dreq;
    e_de = dreq && m_derr(size, addr);
    e_dd = (dreq && !we) ? m_load(size, addr) : '0;
    e_fv = freq;
    e_fe = freq && m_ferr(faddr);
    e_fd = freq ? m_fetch(faddr) : '0;
    if (dreq && we) m_store(size, addr, wdata);
    step();
    d_req = 1'b0;
    f_req = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic edv, input logic [63:0] edd,
                            input logic ede, input logic efv, input logic [79:0] efd,
                            input logic efe);
    chk({tag, ".d_rvalid"}, d_rvalid, edv);
    if (edv) begin
      chk({tag, ".d_rdata"}, d_rdata, edd);
      chk({tag, ".d_err"}, d_err, ede);
    end
    chk({tag, ".f_rvalid"}, f_rvalid, efv);
    if (efv) begin
      chk({tag, ".f_rdata"}, f_rdata, efd);
      chk({tag, ".f_err"}, f_err, efe);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    logic        r_dreq, r_we, r_freq;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_faddr, r_wdata;

    for (int i = 0; i < Depth; i++) mem_m[i] = 8'h00;

    tab[0]  = mk(1, 1, 3, 64'h10,  64'h1122334455667788, 0, 0, 0, 0, 0, 0);
    tab[1]  = mk(1, 0, 1, 64'h11,  0, 0, 0, 64'h6677, 0, 0, 0);
    tab[2]  = mk(1, 0, 0, 64'h17,  0, 0, 0, 64'h11, 0, 0, 0);
    tab[3]  = mk(1, 1, 3, 64'h3F8, 64'h0102030405060708, 0, 0, 0, 0, 0, 0);
    tab[4]  = mk(1, 1, 3, 64'h3F0, 64'hA0A1A2A3A4A5A6A7, 0, 0, 0, 0, 0, 0);
    tab[5]  = mk(1, 1, 3, 64'h3F9, 64'hDEADBEEFDEADBEEF, 0, 0, 0, 1, 0, 0);
    tab[6]  = mk(1, 0, 3, 64'h3F8, 0, 1, 64'h3F7, 64'h0102030405060708, 0, 0, 1);
    tab[7]  = mk(1, 0, 2, 64'h3FC, 0, 1, 64'h3F6, 64'h01020304, 0,
                 80'h0102030405060708A0A1, 0);
    tab[8]  = mk(1, 0, 2, 64'h3FD, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 1);
    tab[9]  = mk(1, 0, 3, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 1, 0, 0);
    tab[10] = mk(1, 0, 0, 64'h3FF, 0, 1, 64'h3F6, 64'h01, 0, 80'h0102030405060708A0A1, 0);
    tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tab[12] = mk(1, 1, 3, 64'h18,  64'hF7F6F5F4F3F2F1F0, 0, 0, 0, 0, 0, 0);
    tab[13] = mk(1, 1, 3, 64'h20,  64'hE7E6E5E4E3E2E1E0, 0, 0, 0, 0, 0, 0);
    tab[14] = mk(1, 1, 2, 64'h20,  64'h55555555AABBCCDD, 1, 64'h1E, 0, 0,
                 80'hE7E6E5E4E3E2E1E0F7F6, 0);
    tab[15] = mk(1, 0, 3, 64'h20,  0, 1, 64'h1E, 64'hE7E6E5E4AABBCCDD, 0,
                 80'hE7E6E5E4AABBCCDDF7F6, 0);
    tab[16] = mk(1, 0, 3, 64'h1D,  0, 0, 0, 64'hE4AABBCCDDF7F6F5, 0, 0, 0);
    tab[17] = mk(1, 0, 1, 64'h3FF, 0, 0, 0, 0, 1, 0, 0);

    // Reset state, then a request during INIT that must be dropped.
    #12;
    chk("rst.d_ready", d_ready, 0);
    chk("rst.f_ready", f_ready, 0);
    chk("rst.init_done", init_done, 0);
    chk("rst.d_rvalid", d_rvalid, 0);
    chk("rst.f_rvalid", f_rvalid, 0);
    chk("rst.d_rdata", d_rdata, 0);
    chk("rst.f_rdata", f_rdata, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 64'h0;
    step();
    n = 1;
    chk("init.req_ignored", d_rvalid, 0);
    d_req = 1'b0;
    while (!init_done && n < 300) begin
      step();
      n++;
    end
    chk("init.cycles", n, ExpInit);
    chk("init.d_ready", d_ready, 1);
    chk("init.f_ready", f_ready, 1);

`ifdef RAM_INIT_CLEAR_EN
    do_cycle(1, 0, 3, 64'h3F8, 0, 0, 0);
    check_resp("clear3f8", 1, 64'h0, 0, 0, 0, 0);
`endif

    for (int w = 0; w < Depth / 8; w++) begin
      do_cycle(1, 1, 3, 64'(w * 8), {$urandom(), $urandom()}, 0, 0);
      check_resp("fill", e_dv, e_dd, e_de, e_fv, e_fd, e_fe);
    end

    for (int i = 0; i < NVec; i++) begin
      do_cycle(tab[i].dreq, tab[i].we, tab[i].size, tab[i].addr, tab[i].wdata,
               tab[i].freq, tab[i].faddr);
      check_resp($sformatf("vec%0d", i), tab[i].dreq, tab[i].edd, tab[i].ede,
                 tab[i].freq, tab[i].efd, tab[i].efe);
    end

    // Reset mid-operation: live response cleared asynchronously, held request never answered.
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd3; d_addr = 64'h3F8;
    f_req = 1'b1; f_addr = 64'h3F6;
    step();
    chk("rstmid.pre_dvalid", d_rvalid, 1);
    chk("rstmid.pre_ddata", d_rdata, 64'h0102030405060708);
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid.d_rvalid", d_rvalid, 0);
    chk("rstmid.d_rdata", d_rdata, 0);
    chk("rstmid.f_rvalid", f_rvalid, 0);
    chk("rstmid.f_rdata", f_rdata, 0);
    chk("rstmid.d_ready", d_ready, 0);
    chk("rstmid.init_done", init_done, 0);
    step();
    chk("rstmid.hold_dvalid", d_rvalid, 0);
    chk("rstmid.hold_fvalid", f_rvalid, 0);
    d_req = 1'b0;
    f_req = 1'b0;

`ifdef RAM_INIT_CLEAR_EN
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (50) step();
    chk("restart.mid_init", init_done, 0);
    #2 rst_i = 1'b1;
    for (int i = 0; i < Depth; i++) mem_m[i] = 8'h00;
`endif
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!init_done && n < 300);
    chk("reinit.cycles", n, ExpInit);
    do_cycle(1, 0, 3, 64'h10, 0, 1, 64'h1E);
    check_resp("post_rst", e_dv, e_dd, e_de, e_fv, e_fd, e_fe);

    for (int k = 0; k < 600; k++) begin
      r_dreq  = ($urandom_range(0, 3) != 0);
      r_we    = $urandom_range(0, 1) == 1;
      r_size  = 2'($urandom_range(0, 3));
      r_wdata = {$urandom(), $urandom()};
      r_freq  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 9))
        0:       r_addr = {$urandom(), $urandom()};
        1, 2:    r_addr = 64'(Depth - 12 + $urandom_range(0, 14));
        default: r_addr = 64'($urandom_range(0, Depth - 1));
      endcase
      case ($urandom_range(0, 9))
        0:       r_faddr = {$urandom(), $urandom()};
        1, 2:    r_faddr = 64'(Depth - 14 + $urandom_range(0, 16));
        default: r_faddr = 64'($urandom_range(0, Depth - 1));
      endcase
      do_cycle(r_dreq, r_we, r_size, r_addr, r_wdata, r_freq, r_faddr);
      check_resp($sformatf("rnd%0d", k), e_dv, e_dd, e_de, e_fv, e_fd, e_fe);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_ram_2p.md
Name: byte_ram_2p

Overview:
- Parametrised, byte-addressed, little-endian unified memory with two ports: a data load/store port (1/2/4/8-byte access) and an instruction fetch port returning FETCH_BYTES bytes.
- Reads are registered with valid/ready handshaking and exact range checking.
- An optional clear sequencer zeroes the array after reset.
- Sits between the CPU pipeline's fetch/memory stages and the storage array.

Parameters:
- DEPTH, 1024: memory size in bytes; must be a multiple of DATA_BYTES.
- ADDR_W, 64: address width of both ports.
- DATA_BYTES, 8: data port width in bytes (power of two, ≥1).
- FETCH_BYTES, 10: bytes returned per fetch.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- d_req_i  in  1  data request.
- d_we_i  in  1  1 = store, 0 = load.
- d_size_i  in  2  access size = 1<<d_size_i bytes.
- d_addr_i  in  ADDR_W  data byte address.
- d_wdata_i  in  DATA_BYTES*8  store data; low bytes are used.
- d_ready_o  out  1  data port can accept a request.
- d_rvalid_o  out  1  data response valid (loads and stores).
- d_rdata_o  out  DATA_BYTES*8  load data, zero-extended.
- d_err_o  out  1  data access error; qualified by d_rvalid_o.
- f_req_i  in  1  fetch request.
- f_addr_i  in  ADDR_W  fetch byte address.
- f_ready_o  out  1  fetch port can accept a request.
- f_rvalid_o  out  1  fetch response valid.
- f_rdata_o  out  FETCH_BYTES*8  fetch data; byte at f_addr_i in bits [7:0].
- f_err_o  out  1  fetch error; qualified by f_rvalid_o.
- init_done_o  out  1  array is ready for use.

Behaviour:
- Reset (async, rst_i=1): d_rvalid_o, f_rvalid_o, d_err_o, f_err_o = 0; d_rdata_o, f_rdata_o = 0; d_ready_o, f_ready_o, init_done_o = 0; FSM goes to INIT (or RUN, see Optional Feature); init counter = 0.
- Reset asserted mid-operation: the in-flight response is dropped, not delivered. Array contents are not touched by rst_i itself.
- FSM states:
  - INIT: ready outputs = 0.
  - RUN: d_ready_o = f_ready_o = 1; init_done_o = 1.
  - RUN is exited only by reset.
- Acceptance: a request is accepted on a rising edge where req_i & ready_o = 1. Requests while ready_o = 0 are ignored and do not need to be held.
- Latency: exactly 1 cycle. Response signals are valid in the cycle after acceptance and held for exactly that one cycle (no backpressure). Back-to-back requests give back-to-back responses.
- Data range error: set when (1<<d_size_i) > DATA_BYTES, or when d_addr_i + (1<<d_size_i) > DEPTH.
  - Evaluate at ADDR_W+1 bits so address wrap cannot hide an error.
  - Example: addr DEPTH-8, size 8 is legal; addr DEPTH-7 is an error.
- Fetch error: set when f_addr_i + FETCH_BYTES > DEPTH, same width rule.
- Loads: d_rdata_o = bytes [addr .. addr+size-1], little-endian, upper bytes 0. On error, d_rdata_o = 0.
- Stores: write bytes [addr .. addr+size-1] from d_wdata_i low bytes at the accepting edge. No bytes are written on error.
  - Response: d_rvalid_o = 1, d_rdata_o = 0, d_err_o = error.
- Fetch: f_rdata_o = FETCH_BYTES bytes from f_addr_i. On error, f_rdata_o = 0.
- Misaligned accesses are legal on both ports.
- Simultaneous data store and fetch of overlapping bytes on the same edge: the fetch returns pre-store data (read-before-write).
- Simultaneous load and fetch are independent.
- A load of bytes stored on the previous edge returns the new data.

Optional Feature:
- Macro: RAM_INIT_CLEAR_EN.
- Defined:
  - After reset release, the FSM sits in INIT and writes zero to DATA_BYTES bytes per cycle at counter*DATA_BYTES.
  - The counter increments to DEPTH/DATA_BYTES-1, then the FSM enters RUN.
  - INIT lasts DEPTH/DATA_BYTES cycles (128 with defaults). Requests arriving during INIT are ignored.
  - A reset during INIT restarts the clear from 0.
- Undefined:
  - The FSM enters RUN on the first rising edge after reset release; ready and init_done go high then.
  - Array contents are undefined until written, and no clear logic is synthesised.

Test Plan:
- With RAM_INIT_CLEAR_EN, release reset → init_done_o rises after exactly 128 cycles. Then load 8 bytes at 0x3F8 → d_rdata_o = 0, d_err_o = 0.
- Store 0x1122334455667788 size 8 at 0x10, next cycle load size 2 at 0x11 → 0x0000000000006677. Load size 1 at 0x17 → 0x11.
- Store size 8 at 0x3F9 (DEPTH-7) → d_rvalid_o = 1, d_err_o = 1, memory unchanged. Fetch at 0x3F7 → f_err_o = 1, f_rdata_o = 0. Fetch at 0x3F6 → f_err_o = 0. Address 0xFFFF_FFFF_FFFF_FFFC → error (no wrap).
- Same edge: store size 4 of 0xAABBCCDD at 0x20 and fetch at 0x1E → fetch returns old bytes. A following fetch at 0x1E → bytes [2..5] = DD CC BB AA.
- Requests on 3 consecutive cycles → 3 consecutive rvalid pulses with matching data. A request during INIT → no rvalid.
- Assert rst_i while a load response is pending → d_rvalid_o never pulses for it. Outputs go to 0 asynchronously, before the next clock edge.
